// File: rtl/lu_pkg.sv
// lu_pkg: shared definitions for the logic unit command sequencer.
//   - opcode encodings understood by the 8-bit logic unit
//   - sequencer FSM state encoding
package lu_pkg;

  localparam int unsigned OP_W = 2;

  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_AND = 2'd0;
  localparam op_t OP_OR  = 2'd1;
  localparam op_t OP_XOR = 2'd2;
  localparam op_t OP_NOR = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2
  } state_t;

endpackage

// File: rtl/res_fifo.sv
// res_fifo: synchronous FIFO holding sequencer results.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   i_push        write i_push_data at the tail (ignored when full)
//   i_push_data   entry to write
//   i_pop         remove the head (ignored when empty)
//   o_head        head entry, combinational from the read pointer
//   o_count       occupancy, 0..DEPTH
module res_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push_en;
  logic             w_pop_en;

  // Pointers wrap naturally because DEPTH is a power of two; count tells full from empty.
  assign w_push_en = i_push && (r_count != CW'(DEPTH));
  assign w_pop_en  = i_pop  && (r_count != '0);

  // Storage array, no reset needed: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (w_push_en) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_en) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop_en) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push_en, w_pop_en})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/lu_seq.sv
// lu_seq: command sequencer and result reader for the logic unit's shared result bus.
// Accepts one command at a time, drives registered operands/opcode to the logic
// unit, waits SETTLE cycles, samples lu_y and queues {op, result} for the consumer.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_a, cmd_b, cmd_op          command operands and opcode
//   lu_a, lu_b, lu_op             registered operands/opcode to the logic unit
//   lu_y                          logic unit result bus (sampled in SAMPLE only)
//   res_valid/res_ready           result handshake
//   res_data, res_op              head result and the opcode that produced it
//   busy                          sequencer not idle
//   count                         result FIFO occupancy
module lu_seq
  import lu_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [WIDTH-1:0]       cmd_a,
  input  logic [WIDTH-1:0]       cmd_b,
  input  logic [1:0]             cmd_op,
  output logic [WIDTH-1:0]       lu_a,
  output logic [WIDTH-1:0]       lu_b,
  output logic [1:0]             lu_op,
  input  logic [WIDTH-1:0]       lu_y,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [WIDTH-1:0]       res_data,
  output logic [1:0]             res_op,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned CW  = $clog2(DEPTH) + 1;
  localparam int unsigned SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned EW  = WIDTH + OP_W;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SCW-1:0]   r_settle;
  logic [SCW-1:0]   w_settle_nxt;
  logic [WIDTH-1:0] r_lu_a;
  logic [WIDTH-1:0] w_lu_a_nxt;
  logic [WIDTH-1:0] r_lu_b;
  logic [WIDTH-1:0] w_lu_b_nxt;
  op_t              r_lu_op;
  op_t              w_lu_op_nxt;
  logic             w_cmd_ready;
  logic             w_push;
  logic [EW-1:0]    w_push_data;
  logic [EW-1:0]    w_head;
  logic [CW-1:0]    w_count;

  // State, settle counter and operand registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_settle <= '0;
      r_lu_a   <= '0;
      r_lu_b   <= '0;
      r_lu_op  <= OP_AND;
    end else begin
      r_state  <= w_state_nxt;
      r_settle <= w_settle_nxt;
      r_lu_a   <= w_lu_a_nxt;
      r_lu_b   <= w_lu_b_nxt;
      r_lu_op  <= w_lu_op_nxt;
    end
  end

  // Next-state logic; cmd_ready depends on registered state and count only.
  always_comb begin
    w_state_nxt  = r_state;
    w_settle_nxt = r_settle;
    w_lu_a_nxt   = r_lu_a;
    w_lu_b_nxt   = r_lu_b;
    w_lu_op_nxt  = r_lu_op;
    w_cmd_ready  = 1'b0;
    w_push       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A free slot is reserved at acceptance, so the later push cannot overflow.
        w_cmd_ready = (w_count < CW'(DEPTH));
        if (cmd_valid && w_cmd_ready) begin
          w_lu_a_nxt   = cmd_a;
          w_lu_b_nxt   = cmd_b;
          w_lu_op_nxt  = op_t'(cmd_op);
          w_settle_nxt = SCW'(SETTLE - 1);
          w_state_nxt  = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (r_settle == '0) begin
          w_state_nxt = ST_SAMPLE;
        end else begin
          w_settle_nxt = r_settle - SCW'(1);
        end
      end
      ST_SAMPLE: begin
        w_push      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_push_data = {r_lu_op, lu_y};

  res_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_res_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (res_ready),
    .o_head      (w_head),
    .o_count     (w_count)
  );

  assign cmd_ready = w_cmd_ready;
  assign lu_a      = r_lu_a;
  assign lu_b      = r_lu_b;
  assign lu_op     = r_lu_op;
  assign res_valid = (w_count != '0);
  assign res_data  = w_head[WIDTH-1:0];
  assign res_op    = w_head[EW-1:WIDTH];
  assign busy      = (r_state != ST_IDLE);
  assign count     = w_count;

endmodule

// File: doc/lu_seq.md
# lu_seq

Command sequencer and result reader for the 8-bit logic unit's shared tri-state result bus. Accepts one operation at a time over a valid/ready command port, drives operands and opcode to the logic unit, holds them for a configurable settle time, samples the result bus and queues `{op, result}` in a small FIFO drained over a valid/ready result port. It sits between the controlling datapath and the logic unit, and is the only consumer of the logic unit's `y` bus.

## Interface
- `WIDTH`, 8: operand/result width.
- `DEPTH`, 4: result FIFO entries; power of two, ≥2.
- `SETTLE`, 1: cycles operands are held before sampling; ≥1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when both high at a rising edge.
- `cmd_a`, `cmd_b`  in  WIDTH  operands.
- `cmd_op`  in  2  0=AND, 1=OR, 2=XOR, 3=NOR.
- `lu_a`, `lu_b`  out  WIDTH  registered operands to the logic unit.
- `lu_op`  out  2  registered opcode to the logic unit.
- `lu_y`  in  WIDTH  logic unit result bus.
- `res_valid`  out  1  FIFO non-empty.
- `res_ready`  in  1  consumer pops the head when `res_valid` is also high.
- `res_data`  out  WIDTH  head result.
- `res_op`  out  2  opcode that produced the head result.
- `busy`  out  1  state ≠ IDLE.
- `count`  out  clog2(DEPTH)+1  FIFO occupancy.

## Operation
- FSM states: IDLE, DRIVE, SAMPLE.
- IDLE: `cmd_ready = (count < DEPTH)`. On handshake, latch `cmd_a/cmd_b/cmd_op` into `lu_a/lu_b/lu_op`, load the settle counter with SETTLE−1, and go to DRIVE.
- DRIVE: hold outputs. Decrement the counter each cycle. Go to SAMPLE in the cycle the counter is 0.
- SAMPLE: push `{lu_op, lu_y}` into the FIFO, then go to IDLE. `cmd_ready` stays low.
- `lu_a/lu_b/lu_op` hold their last command in IDLE. They are never changed outside the IDLE handshake.
- Only one command is in flight. Push can never overflow, because acceptance requires a free slot.
- FIFO: `res_data/res_op` show the head combinationally. Pop on `res_valid && res_ready`.
- Simultaneous push and pop leaves `count` unchanged. Pop with an empty FIFO is ignored.
- Read and write pointers wrap modulo DEPTH. `count` distinguishes full from empty.
- Reset asserted at any time returns the block to IDLE and empties the FIFO. An in-flight command is discarded with no result.

## Timing
- Reset values: state IDLE, `lu_a = lu_b = 0`, `lu_op = 0`, `count = 0`, `res_valid = 0`, `busy = 0`, `cmd_ready = 1`. `res_data/res_op` are undefined while empty.
- Command accepted at edge k:
  - DRIVE spans edges k+1 … k+SETTLE.
  - SAMPLE pushes at edge k+SETTLE+1.
  - `res_valid` rises after edge k+SETTLE+1 if the FIFO was empty.
- Next `cmd_ready` high at the cycle after the push edge, giving a throughput of one command per SETTLE+2 cycles.
- `lu_y` is sampled only in SAMPLE. Its value in other states is ignored.
- `cmd_ready` and `res_valid` are derived from registered state and count only. There is no combinational path from `cmd_valid` or `res_ready` to any output.

## Structure
- Shared package/header `lu_pkg`:
  - opcode constants `OP_AND=2'd0`, `OP_OR=2'd1`, `OP_XOR=2'd2`, `OP_NOR=2'd3`.
  - FSM state encoding `ST_IDLE`, `ST_DRIVE`, `ST_SAMPLE`.
- One sub-module `res_fifo` (synchronous FIFO, width WIDTH+2, depth DEPTH, with count output). The FSM and operand registers live in `lu_seq`.
- The bench instantiates the logic unit alongside `lu_seq`, with `lu_y` driven by its tri-state output.

## Test plan
- Reset, then `a=8'hF0, b=8'h3C`, op 0..3 in turn, `res_ready = 1`:
  - results `8'h30, 8'hFC, 8'hCC, 8'h03` with matching `res_op`.
  - each result appears 2 cycles after acceptance.
- `res_ready = 0` while issuing 5 commands:
  - `count` reaches 4 and `cmd_ready` stays low after the 4th push.
  - the 5th command is not accepted.
  - raising `res_ready` pops in order, and the 5th is then accepted.
- FIFO at count 2 with `res_ready = 1` during a SAMPLE cycle: push and pop in the same edge, `count` stays 2, order is preserved.
- Assert `rst` mid-DRIVE: outputs return to reset values immediately, no result is ever pushed, and `cmd_ready = 1` after deassertion.
- `SETTLE = 3`:
  - `lu_a/lu_b/lu_op` stable for 3 cycles.
  - result pushed at edge k+4.
  - `busy` high for exactly 4 cycles per command.
- `cmd_valid` held high with changing `cmd_a` while busy: only values present at handshake edges are used, and `lu_a` never changes during DRIVE/SAMPLE.
